kf_matvec_seq: RTL and testbench
================================

Name: kf_matvec_seq

Overview:
Upstream operand sequencer for the Kalman-filter sum-of-products (dot-product) stage. It loads a 3x3 matrix and a 3-vector through a valid/ready stream. It then feeds the dot-product stage one (A,B) operand pair at a time, row by row. It collects the three returned dot products into y = M*v.

Parameters:
W, 8, operand and result width in bits
N, 3, matrix dimension; loads N*N matrix words followed by N vector words

Ports:
clk  in  1  single clock; all logic on rising edge
reset  in  1  synchronous, active-low reset (reset==0 resets on the clk edge)
ld_valid  in  1  load word valid
ld_ready  out  1  sequencer accepts load words
ld_data  in  W  load word: M row-major (M[0][0]..M[N-1][N-1]), then v[0]..v[N-1]
pa  out  W  operand A to the dot-product stage (matrix element)
pb  out  W  operand B to the dot-product stage (vector element)
p_valid  out  1  operand pair valid
p_first  out  1  pair is the first term of a row (column 0)
p_last  out  1  pair is the last term of a row (column N-1)
p_ready  in  1  dot-product stage accepts the pair
r_valid  in  1  dot-product result valid (1-cycle pulse)
r_data  in  W  dot-product result
y_data  out  N*W  result vector; y[i] in bits (i+1)*W-1 : i*W
y_valid  out  1  1-cycle pulse when y_data is updated
busy  out  1  high in every state except LOAD

Behaviour:
- Reset values: state LOAD; load counter, row counter r and column counter c = 0. Outputs: p_valid/p_first/p_last/y_valid/busy = 0, pa/pb = 0, y_data = 0, ld_ready = 1 in the cycle after reset. Operand storage is not reset.
- Reset mid-operation: aborts immediately and returns to LOAD. Partial loads and results are discarded, y_data is cleared, and no y_valid is issued.
- FSM states: LOAD, STREAM, WAIT_R, DONE.
- LOAD: ld_ready=1. A word is accepted on ld_valid&&ld_ready and written at the load-counter index. The counter runs 0..N*N+N-1. When word N*N+N-1 is accepted, the counter wraps to 0 and the state goes to STREAM next cycle with r=0, c=0.
- STREAM:
  - Outputs: p_valid=1, pa=M[r][c], pb=v[c], p_first=(c==0), p_last=(c==N-1).
  - All pair outputs stay stable until p_ready. Pairs with p_ready held high are issued on consecutive cycles.
  - On accept with c<N-1: c increments.
  - On accept with c==N-1: c=0 and the state goes to WAIT_R.
- WAIT_R: p_valid=0. On r_valid, y[r] is set to r_data.
  - If r<N-1: r increments and the state returns to STREAM.
  - If r==N-1: the state goes to DONE.
- DONE: y_valid=1 for exactly one cycle, then LOAD with r=0. ld_ready is 0 in DONE.
- y_data is updated per row as results arrive. It holds its value after DONE until the next reset or the next operation's writes.
- r_valid outside WAIT_R is ignored: no state change and no write. The downstream result latency is at least 1 cycle after the last pair is accepted.
- ld_valid outside LOAD is ignored; ld_ready is 0 there.
- No arithmetic in this block. Result overflow/truncation is owned by the dot-product stage; r_data is captured verbatim.
- Minimum operation length with p_ready=1 and result latency L: N*N+N load cycles, then N*(N+L) cycles, then 1 DONE cycle.

Decomposition:
- Shared package kf_pkg: W, N, the load-count constant N*N+N, and the state encoding (LOAD, STREAM, WAIT_R, DONE).
- One natural sub-module: kf_opnd_regfile. It holds the N*N+N word store with a write port indexed by the load counter and two read ports (M[r][c], v[c]).
- FSM and counters stay in kf_matvec_seq.

Test Plan:
- Basic operation:
  - Stimulus: load M=[[1,2,3],[4,5,6],[7,8,9]] and v=[1,1,1]. The bench dot-product model sums the pairs per row with 2-cycle latency; p_ready=1.
  - Response: pairs (1,1)(2,1)(3,1)... issued with p_first on columns 0 and p_last on columns 2. y_data = {24,15,6}; one y_valid pulse; busy drops after DONE.
- Backpressure:
  - Stimulus: same load with p_ready toggled 1,0,0,1,...
  - Response: pa/pb/p_first/p_last stay stable while p_ready=0. The pair count is exactly 9 and y is unchanged = {24,15,6}.
- Spurious and stalled inputs:
  - Stimulus: r_valid pulsed with r_data=8'hAA during LOAD and STREAM, and ld_valid held high during STREAM.
  - Response: y_data unaffected and no extra load words consumed.
- Reset mid-operation:
  - Stimulus: reset=0 for 1 cycle after the second row's pairs.
  - Response: next cycle state is LOAD, y_data=0, y_valid never fires, and a fresh 12-word load then completes correctly.
- Back-to-back operations:
  - Stimulus: operation 1 with v=[1,1,1], then operation 2 with M=identity, v=[5,6,7].
  - Response: y_valid twice; second y_data={7,6,5}. The load counter wraps correctly with no lost or extra word.
- Load stalls:
  - Stimulus: ld_valid gaps between load words.
  - Response: only handshaken words are stored; STREAM starts the cycle after the 12th accept.

Source files
------------

// File: rtl/kf_pkg.sv
// Shared constants and state encoding for the Kalman-filter mat-vec operand sequencer.
package kf_pkg;

    localparam int unsigned KF_W        = 8;
    localparam int unsigned KF_N        = 3;
    localparam int unsigned KF_LD_COUNT = KF_N * KF_N + KF_N;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_STREAM = 2'd1,
        ST_WAIT_R = 2'd2,
        ST_DONE   = 2'd3
    } kf_state_t;

endpackage

// File: rtl/kf_matvec_seq_if.sv
// Load stream, operand-pair stream, result return and y output of the mat-vec sequencer.
interface kf_matvec_seq_if #(
    parameter int unsigned W = kf_pkg::KF_W,
    parameter int unsigned N = kf_pkg::KF_N
);

    logic             ld_valid;
    logic             ld_ready;
    logic [W-1:0]     ld_data;
    logic [W-1:0]     pa;
    logic [W-1:0]     pb;
    logic             p_valid;
    logic             p_first;
    logic             p_last;
    logic             p_ready;
    logic             r_valid;
    logic [W-1:0]     r_data;
    logic [N*W-1:0]   y_data;
    logic             y_valid;
    logic             busy;

    // Environment side: supplies load words, accepts pairs, returns dot products.
    modport master (
        output ld_valid, ld_data, p_ready, r_valid, r_data,
        input  ld_ready, pa, pb, p_valid, p_first, p_last, y_data, y_valid, busy
    );

    // Sequencer side.
    modport slave (
        input  ld_valid, ld_data, p_ready, r_valid, r_data,
        output ld_ready, pa, pb, p_valid, p_first, p_last, y_data, y_valid, busy
    );

endinterface

// File: rtl/kf_opnd_regfile.sv
// Operand store: M row-major in words 0..N*N-1, v in words N*N..N*N+N-1.
module kf_opnd_regfile #(
    parameter int unsigned W  = kf_pkg::KF_W,
    parameter int unsigned N  = kf_pkg::KF_N,
    parameter int unsigned AW = $clog2(N * N + N),
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [IW-1:0] row_i,
    input  logic [IW-1:0] col_i,
    output logic [W-1:0]  m_o,
    output logic [W-1:0]  v_o
);

    localparam int unsigned DEPTH = N * N + N;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] m_addr;
    logic [AW-1:0] v_addr;

    // Storage is intentionally not reset; outputs are gated by the sequencer.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        m_addr = AW'(row_i) * AW'(N) + AW'(col_i);
        v_addr = AW'(N * N) + AW'(col_i);
        m_o    = mem_q[m_addr];
        v_o    = mem_q[v_addr];
    end

endmodule

// File: rtl/kf_matvec_seq.sv
// Operand sequencer: loads M and v, streams (M[r][c], v[c]) pairs row by row, collects y = M*v.
module kf_matvec_seq
    import kf_pkg::*;
#(
    parameter int unsigned W = KF_W,
    parameter int unsigned N = KF_N
) (
    input  logic            clk,
    input  logic            reset,
    kf_matvec_seq_if.slave  bus
);

    localparam int unsigned LDC = N * N + N;
    localparam int unsigned AW  = $clog2(LDC);
    localparam int unsigned IW  = (N > 1) ? $clog2(N) : 1;

    kf_state_t       state_q, state_d;
    logic [AW-1:0]   ld_cnt_q, ld_cnt_d;
    logic [IW-1:0]   r_q, r_d;
    logic [IW-1:0]   c_q, c_d;
    logic [N*W-1:0]  y_q, y_d;
    logic            we;
    logic [W-1:0]    m_rd;
    logic [W-1:0]    v_rd;

    kf_opnd_regfile #(
        .W  (W),
        .N  (N),
        .AW (AW),
        .IW (IW)
    ) u_regfile (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (ld_cnt_q),
        .wdata_i (bus.ld_data),
        .row_i   (r_q),
        .col_i   (c_q),
        .m_o     (m_rd),
        .v_o     (v_rd)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_LOAD;
            ld_cnt_q <= '0;
            r_q      <= '0;
            c_q      <= '0;
            y_q      <= '0;
        end else begin
            state_q  <= state_d;
            ld_cnt_q <= ld_cnt_d;
            r_q      <= r_d;
            c_q      <= c_d;
            y_q      <= y_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ld_cnt_d = ld_cnt_q;
        r_d      = r_q;
        c_d      = c_q;
        y_d      = y_q;
        we       = 1'b0;

        unique case (state_q)
            ST_LOAD: begin
                if (bus.ld_valid) begin
                    we = 1'b1;
                    if (ld_cnt_q == AW'(LDC - 1)) begin
                        ld_cnt_d = '0;
                        r_d      = '0;
                        c_d      = '0;
                        state_d  = ST_STREAM;
                    end else begin
                        ld_cnt_d = ld_cnt_q + 1'b1;
                    end
                end
            end
            ST_STREAM: begin
                if (bus.p_ready) begin
                    if (c_q == IW'(N - 1)) begin
                        c_d     = '0;
                        state_d = ST_WAIT_R;
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                end
            end
            ST_WAIT_R: begin
                if (bus.r_valid) begin
                    y_d[r_q*W +: W] = bus.r_data;
                    if (r_q == IW'(N - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        r_d     = r_q + 1'b1;
                        state_d = ST_STREAM;
                    end
                end
            end
            ST_DONE: begin
                r_d     = '0;
                state_d = ST_LOAD;
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // Pair outputs are forced to zero outside STREAM so the unreset store never leaks out.
    always_comb begin
        bus.ld_ready = (state_q == ST_LOAD);
        bus.p_valid  = (state_q == ST_STREAM);
        bus.pa       = bus.p_valid ? m_rd : '0;
        bus.pb       = bus.p_valid ? v_rd : '0;
        bus.p_first  = bus.p_valid && (c_q == '0);
        bus.p_last   = bus.p_valid && (c_q == IW'(N - 1));
        bus.y_valid  = (state_q == ST_DONE);
        bus.busy     = (state_q != ST_LOAD);
        bus.y_data   = y_q;
    end

endmodule

// File: tb/tb_kf_matvec_seq.sv
// Directed bench for kf_matvec_seq with a 2-cycle-latency dot-product responder.
module tb_kf_matvec_seq;

    logic clk = 1'b0;
    logic reset;

    kf_matvec_seq_if #(.W(8), .N(3)) bus ();

    kf_matvec_seq #(.W(8), .N(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [7:0]  words [12];
    logic [7:0]  m_exp [9];
    logic [7:0]  v_exp [3];
    logic [23:0] y_prev;

    int          pair_cnt = 0;
    int          ld_acc   = 0;
    int          yv_cnt   = 0;
    logic [7:0]  acc      = '0;
    logic [7:0]  res      = '0;
    int          rcnt     = 0;
    bit          spur_req = 1'b0;
    bit          bp       = 1'b0;
    int          bpi      = 0;
    bit          stall_prev = 1'b0;
    logic [18:0] prev_pair  = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_op(input logic [7:0] m [9], input logic [7:0] v [3]);
        for (int i = 0; i < 9; i++) begin
            m_exp[i] = m[i];
            words[i] = m[i];
        end
        for (int i = 0; i < 3; i++) begin
            v_exp[i]   = v[i];
            words[9+i] = v[i];
        end
    endtask

    // Monitor and dot-product model: sampled at the falling edge, where the
    // values present are the ones the next rising edge will see.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.ld_valid && bus.ld_ready) ld_acc++;
            if (bus.y_valid) yv_cnt++;
            if (stall_prev)
                check_eq("bp_stable", {bus.p_valid, bus.p_first, bus.p_last, bus.pa, bus.pb}, prev_pair);
            stall_prev = bus.p_valid && !bus.p_ready;
            prev_pair  = {bus.p_valid, bus.p_first, bus.p_last, bus.pa, bus.pb};
            if (bus.p_valid && bus.p_ready) begin
                if (pair_cnt < 9) begin
                    check_eq("pair_a", bus.pa, m_exp[pair_cnt]);
                    check_eq("pair_b", bus.pb, v_exp[pair_cnt % 3]);
                    check_eq("pair_first_last", {bus.p_first, bus.p_last},
                             {pair_cnt % 3 == 0, pair_cnt % 3 == 2});
                end else begin
                    check_eq("pair_overrun", pair_cnt, 9);
                end
                acc = 8'(acc + bus.pa * bus.pb);
                if (bus.p_last) begin
                    res  = acc;
                    acc  = '0;
                    rcnt = 2;
                end
                pair_cnt++;
            end
        end
    end

    // Responder drives p_ready / r_valid / r_data shortly after each rising edge.
    initial begin
        bus.p_ready = 1'b1;
        bus.r_valid = 1'b0;
        bus.r_data  = '0;
        forever begin
            @(posedge clk);
            #2;
            bus.r_valid = 1'b0;
            if (rcnt == 1) begin
                bus.r_valid = 1'b1;
                bus.r_data  = res;
            end else if (spur_req) begin
                bus.r_valid = 1'b1;
                bus.r_data  = 8'hAA;
                spur_req    = 1'b0;
            end
            if (rcnt > 0) rcnt--;
            bus.p_ready = bp ? ((bpi == 0) || (bpi == 3)) : 1'b1;
            bpi = (bpi + 1) % 4;
        end
    end

    task automatic load_op(input bit gaps, input bit hold, input bit spur);
        int n;
        for (int i = 0; i < 12; i++) begin
            if (gaps && (i % 3 == 1)) begin
                bus.ld_valid = 1'b0;
                bus.ld_data  = 8'h5A;
                @(posedge clk);
                #1;
            end
            if (spur && i == 5) spur_req = 1'b1;
            bus.ld_valid = 1'b1;
            bus.ld_data  = words[i];
            n = 0;
            while (!bus.ld_ready && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (!bus.ld_ready) check_eq("ld_ready_timeout", 0, 1);
            @(posedge clk);
            #1;
        end
        if (hold) bus.ld_data = 8'hEE;
        else      bus.ld_valid = 1'b0;
        check_eq("stream_start", bus.p_valid, 1);
        check_eq("busy_stream", bus.busy, 1);
        if (spur) begin
            check_eq("spur_load", bus.y_data, y_prev);
            spur_req = 1'b1;
            @(posedge clk);
            #1;
            @(posedge clk);
            #1;
            check_eq("spur_stream", bus.y_data, y_prev);
        end
        if (hold) begin
            repeat (3) begin
                @(posedge clk);
                #1;
            end
            check_eq("ld_ready_busy", bus.ld_ready, 0);
            bus.ld_valid = 1'b0;
        end
    endtask

    task automatic finish_op(input logic [23:0] exp_y);
        int n = 0;
        while (!bus.y_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus.y_valid) begin
            check_eq("y_valid_timeout", 0, 1);
        end else begin
            check_eq("y_data", bus.y_data, exp_y);
            check_eq("pair_count", pair_cnt, 9);
            check_eq("ld_words", ld_acc, 12);
            check_eq("ld_ready_done", bus.ld_ready, 0);
            @(negedge clk);
            #1;
            check_eq("y_valid_pulse", bus.y_valid, 0);
            check_eq("busy_after_done", bus.busy, 0);
            check_eq("ld_ready_after", bus.ld_ready, 1);
            check_eq("y_hold", bus.y_data, exp_y);
            check_eq("y_valid_count", yv_cnt, 1);
        end
        y_prev = bus.y_data;
        @(posedge clk);
        #1;
        pair_cnt = 0;
        ld_acc   = 0;
        yv_cnt   = 0;
        acc      = '0;
    endtask

    logic [7:0] m1  [9] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    logic [7:0] mid [9] = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
    logic [7:0] v1  [3] = '{8'd1, 8'd1, 8'd1};
    logic [7:0] v2  [3] = '{8'd5, 8'd6, 8'd7};

    initial begin
        int n;
        reset        = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_data  = '0;
        y_prev       = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        check_eq("rst_ld_ready", bus.ld_ready, 1);
        check_eq("rst_p_valid", {bus.p_valid, bus.p_first, bus.p_last}, 0);
        check_eq("rst_y_valid", bus.y_valid, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_pa_pb", {bus.pa, bus.pb}, 0);
        check_eq("rst_y_data", bus.y_data, 0);

        // Basic, then identity back-to-back
        set_op(m1, v1);
        load_op(1'b0, 1'b0, 1'b0);
        finish_op(24'h180F06);
        set_op(mid, v2);
        load_op(1'b0, 1'b0, 1'b0);
        finish_op(24'h070605);

        // Backpressure with p_ready 1,0,0,1,...
        set_op(m1, v1);
        bp = 1'b1;
        load_op(1'b0, 1'b0, 1'b0);
        finish_op(24'h180F06);
        bp = 1'b0;

        // Spurious r_valid in LOAD/STREAM, ld_valid held during STREAM
        load_op(1'b0, 1'b1, 1'b1);
        finish_op(24'h180F06);

        // Reset after the second row's pairs
        load_op(1'b0, 1'b0, 1'b0);
        n = 0;
        while (!(pair_cnt == 6 && !bus.p_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("mid_reach_row2", pair_cnt, 6);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset    = 1'b1;
        rcnt     = 0;
        acc      = '0;
        pair_cnt = 0;
        ld_acc   = 0;
        check_eq("mid_rst_ld_ready", bus.ld_ready, 1);
        check_eq("mid_rst_busy", bus.busy, 0);
        check_eq("mid_rst_p_valid", bus.p_valid, 0);
        check_eq("mid_rst_y_data", bus.y_data, 0);
        repeat (5) @(posedge clk);
        #1;
        check_eq("mid_rst_no_y_valid", yv_cnt, 0);
        check_eq("mid_rst_idle", bus.busy, 0);

        // Fresh load with ld_valid gaps
        load_op(1'b1, 1'b0, 1'b0);
        finish_op(24'h180F06);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", n_err);
        $fatal(1);
    end

endmodule
